// File: rtl/io_map_pkg.sv
// Address map, status bit positions and display states
// shared by the MMIO peripheral and its testbench.
package io_map_pkg;

  localparam logic [31:0] A_SEG     = 32'h0000_0000;
  localparam logic [31:0] A_LED     = 32'h0000_0004;
  localparam logic [31:0] A_BLINK   = 32'h0000_0008;
  localparam logic [31:0] A_DWELL   = 32'h0000_000C;
  localparam logic [31:0] A_STAT    = 32'h0000_0010;
  localparam logic [31:0] A_TEST    = 32'h0000_0014;
  localparam logic [31:0] A_IN_BASE = 32'h0000_0020;

  localparam int STAT_OVF   = 31;
  localparam int STAT_FULL  = 30;
  localparam int STAT_EMPTY = 29;

  localparam int CTL_CLR_OVF = 0;
  localparam int CTL_FLUSH   = 1;

  typedef enum logic {
    IDLE,
    SHOW
  } disp_state_t;

  function automatic logic [31:0] in_addr(input int k);
    return A_IN_BASE + 32'(4 * k);
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous display FIFO; exposes head and the entry
// behind it so the display can advance without a gap.
module io_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [W-1:0]               second,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rd_nxt  = rd_ptr + AW'(1);
  assign head    = mem[rd_ptr];
  assign second  = mem[rd_nxt];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_periph.sv
// Memory-mapped I/O block: queued 7-seg display with dwell,
// LEDs, blink timer, latched input channels, status/control.
module mmio_periph
  import io_map_pkg::*;
#(
  parameter int SEG_W        = 24,
  parameter int DEPTH        = 32,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int LED_W        = 16,
  parameter int IN_CH        = 2,
  parameter int IN_W         = 8,
  parameter int TEST_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_we,
  input  logic [31:0]       io_addr,
  input  logic [31:0]       io_wdata,
  output logic [31:0]       io_rdata,
  input  logic [IN_CH-1:0]  in_enter,
  input  logic [IN_W-1:0]   in_data,
  input  logic [TEST_W-1:0] test_in,
  output logic [SEG_W-1:0]  seg_out,
  output logic [LED_W-1:0]  led_out,
  output logic              blink_out,
  output logic              q_full,
  output logic              q_empty
);

  localparam int CW = $clog2(DEPTH) + 1;

  disp_state_t      state;
  logic [31:0]      timer;
  logic [31:0]      dwell;
  logic [31:0]      blink_cnt;
  logic             ovf;
  logic [IN_W-1:0]  in_reg [IN_CH];

  logic [SEG_W-1:0] head;
  logic [SEG_W-1:0] second;
  logic [CW-1:0]    count;

  logic wr_seg;
  logic wr_led;
  logic wr_blink;
  logic wr_dwell;
  logic wr_stat;
  logic flush;
  logic pop;

  assign wr_seg   = io_we && (io_addr == A_SEG);
  assign wr_led   = io_we && (io_addr == A_LED);
  assign wr_blink = io_we && (io_addr == A_BLINK);
  assign wr_dwell = io_we && (io_addr == A_DWELL);
  assign wr_stat  = io_we && (io_addr == A_STAT);
  assign flush    = wr_stat && io_wdata[CTL_FLUSH];
  assign pop      = (state == SHOW) && (timer == '0);

  io_fifo #(
    .DEPTH (DEPTH),
    .W     (SEG_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (wr_seg),
    .pop    (pop),
    .flush  (flush),
    .din    (io_wdata[SEG_W-1:0]),
    .head   (head),
    .second (second),
    .count  (count),
    .full   (q_full),
    .empty  (q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state   <= IDLE;
      seg_out <= '0;
      timer   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!q_empty) begin
            seg_out <= head;
            timer   <= dwell - 32'd1;
            state   <= SHOW;
          end
        end
        SHOW: begin
          if (timer != '0) begin
            timer <= timer - 32'd1;
          end else if (count > CW'(1)) begin
            seg_out <= second;
            timer   <= dwell - 32'd1;
          end else begin
            seg_out <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_out   <= '0;
      blink_cnt <= '0;
      dwell     <= 32'(DWELL_CYCLES);
      ovf       <= 1'b0;
    end else begin
      if (wr_led) led_out <= io_wdata[LED_W-1:0];
      if (wr_blink)
        blink_cnt <= io_wdata;
      else if (blink_cnt != '0)
        blink_cnt <= blink_cnt - 32'd1;
      // zero dwell would underflow the timer
      if (wr_dwell)
        dwell <= (io_wdata == '0) ? 32'd1 : io_wdata;
      if (wr_seg && q_full)
        ovf <= 1'b1;
      else if (wr_stat && io_wdata[CTL_CLR_OVF])
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < IN_CH; k++) begin
      if (rst)
        in_reg[k] <= '0;
      else if (in_enter[k])
        in_reg[k] <= in_data;
    end
  end

  assign blink_out = (blink_cnt != '0);

  logic [31:0]     stat;
  logic            hit_in;
  logic [IN_W-1:0] in_sel;
  logic            hit_stat;
  logic            hit_dwell;
  logic            hit_test;

  assign hit_stat  = (io_addr == A_STAT);
  assign hit_dwell = (io_addr == A_DWELL);
  assign hit_test  = (io_addr == A_TEST);

  always_comb begin
    stat             = '0;
    stat[STAT_OVF]   = ovf;
    stat[STAT_FULL]  = q_full;
    stat[STAT_EMPTY] = q_empty;
    stat[CW-1:0]     = count;
  end

  always_comb begin
    hit_in = 1'b0;
    in_sel = '0;
    for (int k = 0; k < IN_CH; k++) begin
      if (io_addr == in_addr(k)) begin
        hit_in = 1'b1;
        in_sel = in_reg[k];
      end
    end
  end

  always_comb begin
    io_rdata = '0;
    if (!io_we) begin
      unique case (1'b1)
        hit_stat:  io_rdata = stat;
        hit_dwell: io_rdata = dwell;
        hit_test:  io_rdata = 32'(test_in);
        hit_in:    io_rdata = 32'(in_sel);
        default:   io_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_periph.sv
// Testbench for mmio_periph: directed vector table, corner
// sequences, then random traffic against a queue-based model.
module tb_mmio_periph;
  import io_map_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DW     = 4;
  localparam int SEG_W  = 24;
  localparam int LED_W  = 16;
  localparam int IN_CH  = 2;
  localparam int IN_W   = 8;
  localparam int TEST_W = 3;

  logic              clk;
  logic              rst;
  logic              io_we;
  logic [31:0]       io_addr;
  logic [31:0]       io_wdata;
  logic [31:0]       io_rdata;
  logic [IN_CH-1:0]  in_enter;
  logic [IN_W-1:0]   in_data;
  logic [TEST_W-1:0] test_in;
  logic [SEG_W-1:0]  seg_out;
  logic [LED_W-1:0]  led_out;
  logic              blink_out;
  logic              q_full;
  logic              q_empty;

  mmio_periph #(
    .SEG_W        (SEG_W),
    .DEPTH        (DEPTH),
    .DWELL_CYCLES (DW),
    .LED_W        (LED_W),
    .IN_CH        (IN_CH),
    .IN_W         (IN_W),
    .TEST_W       (TEST_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .in_enter  (in_enter),
    .in_data   (in_data),
    .test_in   (test_in),
    .seg_out   (seg_out),
    .led_out   (led_out),
    .blink_out (blink_out),
    .q_full    (q_full),
    .q_empty   (q_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: queue of words, display = front while showing
  logic [SEG_W-1:0] mq[$];
  bit               m_show;
  longint           m_left;
  longint           m_dwell;
  bit               m_ovf;
  logic [LED_W-1:0] m_led;
  longint           m_blink;
  logic [IN_W-1:0]  m_in [IN_CH];

  function automatic void m_reset();
    mq.delete();
    m_show  = 0;
    m_left  = 0;
    m_dwell = DW;
    m_ovf   = 0;
    m_led   = '0;
    m_blink = 0;
    for (int k = 0; k < IN_CH; k++) m_in[k] = '0;
  endfunction

  function automatic void m_step();
    int     pre;
    longint d;
    bit     fl;
    logic [SEG_W-1:0] tmp;
    if (rst) begin
      m_reset();
      return;
    end
    pre = mq.size();
    d   = m_dwell;
    fl  = io_we && io_addr == A_STAT && io_wdata[1];
    if (fl) begin
      mq.delete();
      m_show = 0;
    end else begin
      if (!m_show) begin
        if (pre > 0) begin
          m_show = 1;
          m_left = d;
        end
      end else if (m_left > 1) begin
        m_left--;
      end else begin
        tmp = mq.pop_front();
        if (pre > 1) m_left = d;
        else m_show = 0;
      end
      if (io_we && io_addr == A_SEG) begin
        if (pre < DEPTH) mq.push_back(io_wdata[SEG_W-1:0]);
        else m_ovf = 1;
      end
    end
    if (io_we && io_addr == A_BLINK) m_blink = longint'(io_wdata);
    else if (m_blink > 0) m_blink--;
    if (io_we && io_addr == A_LED) m_led = io_wdata[LED_W-1:0];
    if (io_we && io_addr == A_DWELL)
      m_dwell = (io_wdata == 0) ? 1 : longint'(io_wdata);
    if (io_we && io_addr == A_STAT && io_wdata[0]) m_ovf = 0;
    for (int k = 0; k < IN_CH; k++)
      if (in_enter[k]) m_in[k] = in_data;
  endfunction

  function automatic logic [31:0] m_read();
    int n = mq.size();
    if (io_we) return 32'h0;
    if (io_addr == A_STAT)
      return {m_ovf, n == DEPTH, n == 0, 29'(n)};
    if (io_addr == A_DWELL) return m_dwell[31:0];
    if (io_addr == A_TEST) return 32'(test_in);
    for (int k = 0; k < IN_CH; k++)
      if (io_addr == A_IN_BASE + 32'(4 * k)) return 32'(m_in[k]);
    return 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] a,
                       input logic [31:0] d);
    io_we    = we;
    io_addr  = a;
    io_wdata = d;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_seg"}, 32'(seg_out),
        m_show ? 32'(mq[0]) : 32'h0);
    chk({tag, "_led"}, 32'(led_out), 32'(m_led));
    chk({tag, "_blink"}, 32'(blink_out), 32'(m_blink != 0));
    chk({tag, "_full"}, 32'(q_full), 32'(mq.size() == DEPTH));
    chk({tag, "_empty"}, 32'(q_empty), 32'(mq.size() == 0));
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  enter;
    logic [7:0]  din;
    logic [31:0] exp_rd;
    logic [23:0] exp_seg;
  } vec_t;

  vec_t        tbl [19];
  logic [31:0] addrs [10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{0, A_STAT,      0,         0, 0,    32'h2000_0000, 0};
    tbl[1]  = '{0, A_DWELL,     0,         0, 0,    32'd4,         0};
    tbl[2]  = '{1, A_SEG,       32'hA,     0, 0,    0,             0};
    tbl[3]  = '{1, A_SEG,       32'hB,     0, 0,    0,             24'hA};
    tbl[4]  = '{0, A_STAT,      0,         0, 0,    32'h0000_0002, 24'hA};
    tbl[5]  = '{0, A_SEG,       0,         0, 0,    0,             24'hA};
    tbl[6]  = '{0, A_SEG,       0,         0, 0,    0,             24'hA};
    tbl[7]  = '{0, A_SEG,       0,         0, 0,    0,             24'hB};
    tbl[8]  = '{0, A_SEG,       0,         0, 0,    0,             24'hB};
    tbl[9]  = '{0, A_SEG,       0,         0, 0,    0,             24'hB};
    tbl[10] = '{0, A_SEG,       0,         0, 0,    0,             24'hB};
    tbl[11] = '{0, A_STAT,      0,         0, 0,    32'h0000_0001, 0};
    tbl[12] = '{0, A_STAT,      0,         0, 0,    32'h2000_0000, 0};
    tbl[13] = '{0, A_IN_BASE+4, 0,         2, 8'h5A, 0,            0};
    tbl[14] = '{0, A_IN_BASE+4, 0,         0, 0,    32'h5A,        0};
    tbl[15] = '{0, A_IN_BASE,   0,         0, 0,    0,             0};
    tbl[16] = '{1, A_IN_BASE+4, 32'h1234,  0, 0,    0,             0};
    tbl[17] = '{0, A_TEST,      0,         0, 0,    32'h5,         0};
    tbl[18] = '{1, A_STAT,      0,         0, 0,    0,             0};

    addrs = '{A_SEG, A_LED, A_BLINK, A_DWELL, A_STAT, A_TEST,
              A_IN_BASE, A_IN_BASE + 4, A_IN_BASE + 8, 32'h3};

    rst      = 1'b1;
    in_enter = '0;
    in_data  = '0;
    test_in  = 3'b101;
    drive(0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    chk("rst_seg", 32'(seg_out), 0);
    chk("rst_led", 32'(led_out), 0);
    chk("rst_blink", 32'(blink_out), 0);
    chk("rst_full", 32'(q_full), 0);
    chk("rst_empty", 32'(q_empty), 1);

    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].addr, tbl[i].wdata);
      in_enter = tbl[i].enter;
      in_data  = tbl[i].din;
      #1;
      chk($sformatf("tbl%0d_rd", i), io_rdata, tbl[i].exp_rd);
      tick();
      chk($sformatf("tbl%0d_seg", i), 32'(seg_out),
          32'(tbl[i].exp_seg));
    end
    in_enter = '0;

    // overflow while display is stalled on a long dwell
    drive(1, A_DWELL, 1000);
    tick();
    for (int i = 1; i <= 5; i++) begin
      drive(1, A_SEG, 32'(8'h10 + i));
      tick();
    end
    drive(0, A_STAT, 0);
    #1;
    chk("ovf_stat", io_rdata, 32'hC000_0004);
    chk("ovf_full", 32'(q_full), 1);
    chk("ovf_seg", 32'(seg_out), 32'h11);
    drive(1, A_STAT, 1);
    tick();
    drive(0, A_STAT, 0);
    #1;
    chk("ovf_clr", io_rdata, 32'h4000_0004);
    drive(1, A_STAT, 2);
    tick();
    chk("flush_seg", 32'(seg_out), 0);
    drive(0, A_STAT, 0);
    #1;
    chk("flush_stat", io_rdata, 32'h2000_0000);

    // zero dwell behaves as one cycle
    drive(1, A_DWELL, 0);
    tick();
    drive(0, A_DWELL, 0);
    #1;
    chk("dwell0_rd", io_rdata, 1);
    drive(1, A_SEG, 7);
    tick();
    drive(0, 0, 0);
    chk("d1_seg_a", 32'(seg_out), 0);
    tick();
    chk("d1_seg_b", 32'(seg_out), 7);
    tick();
    chk("d1_seg_c", 32'(seg_out), 0);

    // blink pulse and rewrite during pulse
    drive(1, A_BLINK, 3);
    tick();
    drive(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("blink3_%0d", i), 32'(blink_out), 1);
      tick();
    end
    chk("blink3_end", 32'(blink_out), 0);
    drive(1, A_BLINK, 3);
    tick();
    drive(0, 0, 0);
    tick();
    drive(1, A_BLINK, 5);
    tick();
    drive(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("blink5_%0d", i), 32'(blink_out), 1);
      tick();
    end
    chk("blink5_end", 32'(blink_out), 0);

    // reset in the middle of a display
    drive(1, A_LED, 32'hBEEF);
    tick();
    drive(1, A_SEG, 32'h99);
    tick();
    drive(1, A_SEG, 32'h98);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, A_DWELL, 0);
    #1;
    chk("mrst_dwell", io_rdata, DW);
    chk("mrst_seg", 32'(seg_out), 0);
    chk("mrst_led", 32'(led_out), 0);
    chk("mrst_empty", 32'(q_empty), 1);
    check_model("mrst");

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      int r;
      r        = $urandom_range(0, 99);
      rst      = 1'b0;
      in_enter = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      in_data  = 8'($urandom);
      test_in  = 3'($urandom);
      if (r < 35)      drive(1, A_SEG, $urandom);
      else if (r < 43) drive(1, A_DWELL, $urandom_range(0, 6));
      else if (r < 52) drive(1, A_BLINK, $urandom_range(0, 8));
      else if (r < 58) drive(1, A_LED, $urandom);
      else if (r < 63) drive(1, A_STAT, $urandom_range(0, 3));
      else if (r < 65) begin
        rst = 1'b1;
        drive(0, 0, 0);
      end else
        drive(r[0], addrs[$urandom_range(0, 9)], $urandom);
      #1;
      chk($sformatf("rnd%0d_rd", c), io_rdata, m_read());
      tick();
      check_model($sformatf("rnd%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
